// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame-level sequencer for the sobel_filter datapath.
// Accepts a frame request, pulses the filter start, streams N=W*H input
// pixel addresses in raster order, captures up to M=(W-2)*(H-2) filter
// outputs at consecutive write addresses, then reports done / error.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_req, abort  host control (frame_req sampled in IDLE only)
//   frame_ack         one-cycle pulse on request accept
//   busy              high in every state but IDLE
//   frame_done        one-cycle pulse on frame completion
//   frame_err         error status, valid with frame_done, held until next accept
//   aborted           one-cycle pulse when an abort is taken
//   rd_en, rd_addr    input frame buffer read port
//   flt_start         filter start pulse
//   flt_valid_out     filter output valid
//   flt_done          filter frame done
//   wr_en, wr_addr    output frame buffer write port (same-cycle as flt_valid_out)
module sobel_frame_ctrl #(
   parameter int unsigned IMG_WIDTH     = 256,
   parameter int unsigned IMG_HEIGHT    = 256,
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned DRAIN_TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_req,
   input  logic              abort,
   output logic              frame_ack,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic              aborted,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              flt_start,
   input  logic              flt_valid_out,
   input  logic              flt_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned NOUT = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
   localparam int unsigned TO_W = $clog2(DRAIN_TIMEOUT + 1);

   localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(NPIX - 1);
   localparam logic [ADDR_W-1:0] WR_MAX  = ADDR_W'(NOUT);
   localparam logic [TO_W-1:0]   TO_LIM  = TO_W'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   logic [ADDR_W-1:0] wcnt;
   logic [TO_W-1:0]   tcnt;
   logic              ovf;

   // next-cycle values of registered outputs and counters
   logic              frame_ack_d;
   logic              busy_d;
   logic              frame_done_d;
   logic              frame_err_d;
   logic              aborted_d;
   logic              rd_en_d;
   logic [ADDR_W-1:0] rd_addr_d;
   logic              flt_start_d;
   logic [ADDR_W-1:0] wcnt_d;
   logic [TO_W-1:0]   tcnt_d;
   logic              ovf_d;

   logic              accept;
   logic              abort_take;
   logic              capture;
   logic              ovf_now;
   logic [TO_W-1:0]   tcnt_inc;
   logic              timeout_hit;

   assign accept      = (state == S_IDLE) && frame_req;
   assign abort_take  = (state != S_IDLE) && abort;
   assign tcnt_inc    = tcnt + TO_W'(1);
   assign timeout_hit = (state == S_DRAIN) && (tcnt_inc == TO_LIM);

   // Output capture: writes are combinational so they land with the filter valid.
   assign capture = (state == S_FEED) || (state == S_DRAIN) || (state == S_DONE);
   assign wr_en   = capture && flt_valid_out && (wcnt < WR_MAX);
   assign ovf_now = capture && flt_valid_out && (wcnt >= WR_MAX);
   assign wr_addr = wcnt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state logic; abort overrides every other transition
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (frame_req) next_state = S_START;
         S_START: next_state = S_FEED;
         S_FEED:  if (rd_addr == LAST_RD) next_state = S_DRAIN;
         S_DRAIN: if (flt_done || timeout_hit) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (abort_take) next_state = S_IDLE;
   end

   // Output / counter next values, decoded from the upcoming state
   always_comb begin
      frame_ack_d  = accept;
      busy_d       = (next_state != S_IDLE);
      flt_start_d  = (next_state == S_START);
      rd_en_d      = (next_state == S_FEED);
      frame_done_d = (next_state == S_DONE);
      aborted_d    = abort_take;
      rd_addr_d    = rd_addr;
      wcnt_d       = wcnt;
      tcnt_d       = tcnt;
      ovf_d        = ovf | ovf_now;
      frame_err_d  = frame_err;

      if (accept) begin
         rd_addr_d   = '0;
         wcnt_d      = '0;
         tcnt_d      = '0;
         ovf_d       = 1'b0;
         frame_err_d = 1'b0;
      end else begin
         if ((state == S_FEED) && (next_state == S_FEED))
            rd_addr_d = rd_addr + ADDR_W'(1);
         if (wr_en)
            wcnt_d = wcnt + ADDR_W'(1);
         if (state == S_DRAIN)
            tcnt_d = tcnt_inc;
         // Error is evaluated on DONE entry with this cycle's write included;
         // a flt_done coinciding with the timeout counts as a normal finish.
         if ((state == S_DRAIN) && (next_state == S_DONE))
            frame_err_d = (timeout_hit && !flt_done) || (wcnt_d != WR_MAX) || ovf_d;
         else if (state == S_DONE)
            frame_err_d = frame_err | ovf_now;
      end
   end

   // Registered outputs and datapath counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_ack  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         aborted    <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         flt_start  <= 1'b0;
         wcnt       <= '0;
         tcnt       <= '0;
         ovf        <= 1'b0;
      end else begin
         frame_ack  <= frame_ack_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
         frame_err  <= frame_err_d;
         aborted    <= aborted_d;
         rd_en      <= rd_en_d;
         rd_addr    <= rd_addr_d;
         flt_start  <= flt_start_d;
         wcnt       <= wcnt_d;
         tcnt       <= tcnt_d;
         ovf        <= ovf_d;
      end
   end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: self-checking bench for sobel_frame_ctrl on an 8x6 frame.
// A behavioural filter model drives flt_valid_out / flt_done; expected write
// addresses go into a queue as valids are driven and are popped on wr_en.
module tb_sobel_frame_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned H  = 6;
   localparam int unsigned AW = 16;
   localparam int unsigned TO = 16;
   localparam int N      = W * H;
   localparam int M      = (W - 2) * (H - 2);
   localparam int VSTART = 30;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_req = 1'b0;
   logic          abort = 1'b0;
   logic          frame_ack, busy, frame_done, frame_err, aborted;
   logic          rd_en, flt_start, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic          flt_valid_out = 1'b0;
   logic          flt_done = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int wq[$];

   always #5 clk = ~clk;

   sobel_frame_ctrl #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .DRAIN_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .frame_req(frame_req), .abort(abort),
      .frame_ack(frame_ack), .busy(busy), .frame_done(frame_done),
      .frame_err(frame_err), .aborted(aborted),
      .rd_en(rd_en), .rd_addr(rd_addr), .flt_start(flt_start),
      .flt_valid_out(flt_valid_out), .flt_done(flt_done),
      .wr_en(wr_en), .wr_addr(wr_addr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One frame. hold: 0 pulse req, 1 hold req throughout, 2 hold req until frame_done.
   // Starts and ends at posedge+1; start_rel=1 continues a frame accepted in the
   // previous call's final IDLE cycle.
   task automatic run_frame(input int nvalid, input bit give_done, input int abort_at,
                            input int rst_at, input int hold, input int start_rel,
                            input bit exp_err);
      int  exp_w     = 0;
      int  exp_rd    = 0;
      int  last_wr   = -1;
      int  done_rel  = -1;
      int  abort_rel = -1;
      bit  err_done  = 1'b0;
      bit  fin       = 1'b0;
      bit  ovf_cyc;
      int  exp_done_rel;
      int  exp_last;
      exp_done_rel = give_done ? (VSTART + nvalid + 3) : (N + 2 + int'(TO));
      exp_last     = ((nvalid < M) ? nvalid : M) - 1;
      wq.delete();
      for (int rel = start_rel; rel < 250 && !fin; rel++) begin
         case (hold)
            1:       frame_req = 1'b1;
            2:       frame_req = (done_rel < 0);
            default: frame_req = (rel == 0);
         endcase
         abort         = (rel == abort_at);
         flt_valid_out = (rel >= VSTART) && (rel < VSTART + nvalid);
         flt_done      = give_done && (rel == VSTART + nvalid + 2);
         ovf_cyc       = 1'b0;
         if (flt_valid_out) begin
            if (exp_w < M) begin
               wq.push_back(exp_w);
               exp_w++;
            end else begin
               ovf_cyc = 1'b1;
            end
         end
         @(negedge clk);
         if (rel == 1) begin
            chk("ack", frame_ack, 1);
            chk("flt_start", flt_start, 1);
            chk("busy_start", busy, 1);
         end
         chk("rd_en", rd_en, (rel >= 2) && (rel <= N + 1) && (abort_at < 0 || rel <= abort_at));
         if (rd_en) begin
            chk("rd_addr", rd_addr, exp_rd);
            exp_rd++;
         end
         if (ovf_cyc) chk("ovf_wr_en", wr_en, 0);
         if (wr_en) begin
            if (wq.size() == 0) chk("wr_extra", wr_en, 0);
            else                chk("wr_addr", wr_addr, wq.pop_front());
            last_wr = int'(wr_addr);
         end
         if (done_rel >= 0 && rel == done_rel + 1) begin
            chk("done_1cyc", frame_done, 0);
            chk("busy_fall", busy, 0);
            chk("err_hold", frame_err, err_done);
            fin = 1'b1;
         end
         if (frame_done && done_rel < 0) begin
            done_rel = rel;
            err_done = frame_err;
         end
         if (aborted && abort_rel < 0) begin
            abort_rel = rel;
            chk("abort_busy", busy, 0);
            fin = 1'b1;
         end
         if (rel == rst_at) begin
            chk("busy_pre_rst", busy, 1);
            #2 rst_n = 1'b0;
            #1 chk("rst_outs", {frame_ack, busy, frame_done, frame_err, aborted,
                                rd_en, flt_start, wr_en, rd_addr, wr_addr}, 0);
            fin = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      abort         = 1'b0;
      flt_valid_out = 1'b0;
      flt_done      = 1'b0;
      if (rst_at >= 0) begin
         chk("rst_no_done", done_rel, -1);
      end else if (abort_at >= 0) begin
         chk("abort_rel", abort_rel, abort_at + 1);
         chk("abort_no_done", done_rel, -1);
         chk("abort_rd_cnt", exp_rd, abort_at - 1);
      end else begin
         chk("done_rel", done_rel, exp_done_rel);
         chk("frame_err", err_done, exp_err);
         chk("rd_cnt", exp_rd, N);
         chk("last_wr", last_wr, exp_last);
         chk("wq_empty", wq.size(), 0);
      end
   endtask

   initial begin
      #1 chk("reset_outs", {frame_ack, busy, frame_done, frame_err, aborted,
                            rd_en, flt_start, wr_en, rd_addr, wr_addr}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_frame(24, 1'b1, -1, -1, 0, 0, 1'b0);   // nominal
      run_frame(23, 1'b1, -1, -1, 0, 0, 1'b1);   // underflow
      run_frame(25, 1'b1, -1, -1, 0, 0, 1'b1);   // overflow
      run_frame(24, 1'b0, -1, -1, 0, 0, 1'b1);   // drain timeout
      run_frame(24, 1'b1, 12, -1, 0, 0, 1'b0);   // abort at rd_addr 10
      run_frame(24, 1'b1, -1, -1, 0, 0, 1'b0);   // restart after abort
      run_frame(24, 1'b1, -1, -1, 1, 0, 1'b0);   // req held: frame 1
      run_frame(24, 1'b1, -1, -1, 2, 1, 1'b0);   // req held: frame 2
      run_frame(24, 1'b1, -1, 20, 0, 0, 1'b0);   // async reset in FEED
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_frame(24, 1'b1, -1, -1, 0, 0, 1'b0);   // recovery after reset

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level sequencer for the `sobel_filter` datapath. On a frame request it pulses the filter's start and streams input pixels from a synchronous-read input frame buffer, one pixel per clock, in raster order. It writes each valid filter output to an output frame buffer at consecutive addresses, then reports completion and an error flag. It sits between the host/register block and the filter plus its two frame memories.

## Interface
- `IMG_WIDTH`, 256, input frame width in pixels (≥3)
- `IMG_HEIGHT`, 256, input frame height in pixels (≥3)
- `ADDR_W`, 16, address width for both buffers; must hold IMG_WIDTH*IMG_HEIGHT-1
- `DRAIN_TIMEOUT`, 4096, max cycles in DRAIN waiting for `flt_done`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_req`  in  1  level request to process one frame; sampled only in IDLE
- `abort`  in  1  cancel the current frame; ignored in IDLE
- `frame_ack`  out  1  one-cycle pulse: request accepted
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse: frame finished (not pulsed on abort)
- `frame_err`  out  1  valid with `frame_done`, held until the next accept: output count mismatch or timeout
- `aborted`  out  1  one-cycle pulse: abort taken
- `rd_en`  out  1  input-buffer read enable; data returns 1 cycle later on filter `pixel_in`
- `rd_addr`  out  ADDR_W  input-buffer read address
- `flt_start`  out  1  to filter `start`
- `flt_valid_out`  in  1  from filter `valid_out`
- `flt_done`  in  1  from filter `done`
- `wr_en`  out  1  output-buffer write enable (data bus is wired filter `pixel_out` → memory)
- `wr_addr`  out  ADDR_W  output-buffer write address

## Operation
- States: IDLE, START, FEED, DRAIN, DONE.
- IDLE: `frame_req`=1 → START, with `frame_ack` pulsed in the same cycle as the transition. Clear read, write, timeout and `frame_err` state.
- START: `flt_start`=1 for exactly one cycle → FEED.
- FEED: `rd_en`=1 and `rd_addr`=0,1,…,N-1 on consecutive cycles, where N=IMG_WIDTH*IMG_HEIGHT. After the cycle with `rd_addr`=N-1 → DRAIN.
- DRAIN: `rd_en`=0 and the timeout counter increments. On `flt_done`=1 → DONE. When the counter reaches DRAIN_TIMEOUT → DONE with the timeout error set.
- DONE: `frame_done`=1 for one cycle → IDLE.
- Output capture runs in FEED, DRAIN and DONE:
  - `wr_en` = `flt_valid_out` while the write count is below M=(IMG_WIDTH-2)*(IMG_HEIGHT-2).
  - `wr_addr` starts at 0 and increments after each write.
  - A `flt_valid_out` at count M is suppressed (`wr_en`=0) and sets the error.
- `frame_err` = timeout OR write count ≠ M when DONE is entered, OR overflow.
- `abort` in START/FEED/DRAIN/DONE → IDLE next cycle. `aborted` is pulsed, `frame_done` is not, and the filter is not reset.
- `frame_req` outside IDLE is ignored; it needs no deassertion between frames.
- Abort and `flt_done` in the same cycle: abort wins.
- Counters are ADDR_W bits with no wrap; the timeout counter is clog2(DRAIN_TIMEOUT+1) bits.

## Timing
- Reset values: all outputs 0; `rd_addr`=0, `wr_addr`=0; state IDLE.
- All outputs are registered, except that `wr_en` and `wr_addr` are combinational from `flt_valid_out` and the registered count, so a write lands in the same cycle as the valid output.
- Cycle numbering (cycle 0 = `frame_req` sampled high in IDLE):
  - cycle 1: `frame_ack`, `busy`=1, START; `flt_start`=1.
  - cycles 2…N+1: `rd_en`=1 with `rd_addr` 0…N-1.
  - Pixel k reaches the filter at cycle k+3, one cycle after it is addressed.
- `frame_done` asserts the cycle after `flt_done` is seen in DRAIN. `busy` drops the cycle after that.
- An asynchronous reset mid-frame returns to IDLE immediately with all outputs 0.

## Test plan
- 8x6 frame with a filter model producing 24 valid outputs then `done`: `rd_addr` 0..47 on 48 consecutive cycles; `wr_addr` 0..23; `frame_done`=1 with `frame_err`=0; `busy` falls one cycle after `frame_done`.
- Model emits only 23 valid outputs before `done`: `frame_done`=1, `frame_err`=1, last `wr_addr` written is 22.
- Model emits 25 valid outputs: the 25th has `wr_en`=0 and `frame_err`=1.
- Model never asserts `done`, with DRAIN_TIMEOUT=16: DONE is reached 16 cycles into DRAIN and `frame_err`=1.
- `abort` at `rd_addr`=10: `aborted` pulses, `busy`=0 on the next cycle, no `frame_done`. A following `frame_req` restarts at `rd_addr`=0.
- `frame_req` held high across two frames: two `frame_ack`, two `frame_done`, and a single IDLE cycle between them. `rst_n` low during FEED: all outputs 0 asynchronously.
